// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, counter limits and default prescale for the stopwatch.
package stopwatch_pkg;
  typedef enum logic [1:0] {STOP = 2'd0, RUN = 2'd1, CLEAR = 2'd2} state_t;
  localparam logic [6:0] MSEC_MAX = 7'd99;
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam int TICK_DIV_DEFAULT = 1_000_000;
endpackage

// File: rtl/stopwatch_core_tick_gen.sv
// tick_gen: gated prescaler; holds while disabled so a paused stopwatch resumes mid-tick.
module tick_gen
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] cnt;
  assign tick = en && cnt == LAST;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: run/stop/clear control FSM driving a centisecond..hour rollover counter chain.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run_stop,
  input  logic       btn_clear,
  output logic [6:0] msec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       running
);
  state_t state, next;
  logic tick, msec_w, sec_w, min_w;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= STOP;
      running <= 1'b0;
    end else begin
      state   <= next;
      running <= next == RUN;
    end
  end
  // Clear has priority in STOP; in RUN only run/stop matters; CLEAR always lasts one cycle.
  always_comb begin
    next = state;
    next = state == CLEAR ? STOP :
           state == STOP  ? (btn_clear ? CLEAR : btn_run_stop ? RUN : STOP) :
                            (btn_run_stop ? STOP : RUN);
  end
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (state == RUN),
    .clr  (state == CLEAR),
    .tick (tick)
  );
  assign msec_w = msec == MSEC_MAX;
  assign sec_w  = sec == SEC_MAX;
  assign min_w  = min == MIN_MAX;
  always_ff @(posedge clk or posedge reset) begin
    if (reset || state == CLEAR) begin
      msec <= '0;
      sec  <= '0;
      min  <= '0;
      hour <= '0;
    end else if (tick) begin
      msec <= msec_w ? '0 : msec + 1'b1;
      if (msec_w) sec <= sec_w ? '0 : sec + 1'b1;
      if (msec_w && sec_w) min <= min_w ? '0 : min + 1'b1;
      if (msec_w && sec_w && min_w) hour <= hour == HOUR_MAX ? '0 : hour + 1'b1;
    end
  end
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed checks of control, prescale timing and rollover with TICK_DIV=4.
module tb_stopwatch_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_run_stop = 1'b0;
  logic btn_clear = 1'b0;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic running;
  int vectors = 0;
  int errors = 0;

  stopwatch_core #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_run_stop(btn_run_stop),
    .btn_clear   (btn_clear),
    .msec        (msec),
    .sec         (sec),
    .min         (min),
    .hour        (hour),
    .running     (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic rs, input logic cl);
    btn_run_stop = rs;
    btn_clear = cl;
    step(1);
    btn_run_stop = 1'b0;
    btn_clear = 1'b0;
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s, input int cs);
    chk({tag, ".hour"}, 32'(hour), 32'(h));
    chk({tag, ".min"}, 32'(min), 32'(m));
    chk({tag, ".sec"}, 32'(sec), 32'(s));
    chk({tag, ".msec"}, 32'(msec), 32'(cs));
  endtask

  initial begin
    step(2);
    #2 reset = 1'b0;
    step(1);
    chk_time("reset", 0, 0, 0, 0);
    chk("reset.running", 32'(running), 0);

    // run 400 cycles from a cleared prescaler
    pulse(1'b1, 1'b0);
    chk("run.running", 32'(running), 1);
    chk("run.msec0", 32'(msec), 0);
    step(3);
    chk("run.before_first", 32'(msec), 0);
    step(1);
    chk("run.first_tick", 32'(msec), 1);
    step(391);
    chk("run.c395", 32'(msec), 98);
    step(1);
    chk("run.c396", 32'(msec), 99);
    step(3);
    chk("run.c399", 32'(msec), 99);
    step(1);
    chk_time("run.c400", 0, 0, 1, 0);

    // clear ignored in RUN, then stop and clear
    pulse(1'b0, 1'b1);
    chk("clr_in_run.running", 32'(running), 1);
    chk("clr_in_run.sec", 32'(sec), 1);
    pulse(1'b1, 1'b0);
    chk("stop.running", 32'(running), 0);
    chk("stop.sec", 32'(sec), 1);
    pulse(1'b0, 1'b1);
    chk("clear.k.sec", 32'(sec), 1);
    chk("clear.k.running", 32'(running), 0);
    step(1);
    chk_time("clear.k1", 0, 0, 0, 0);
    chk("clear.k1.running", 32'(running), 0);

    // pause mid-tick and resume
    pulse(1'b1, 1'b0);
    step(5);
    chk("pause.msec_run", 32'(msec), 1);
    pulse(1'b1, 1'b0);
    chk("pause.running", 32'(running), 0);
    step(50);
    chk("pause.hold", 32'(msec), 1);
    pulse(1'b1, 1'b0);
    chk("resume.running", 32'(running), 1);
    chk("resume.r0", 32'(msec), 1);
    step(1);
    chk("resume.r1", 32'(msec), 1);
    step(1);
    chk("resume.r2", 32'(msec), 2);

    // both pulses in RUN: stop, keep time
    pulse(1'b1, 1'b1);
    chk("both_run.running", 32'(running), 0);
    chk("both_run.msec", 32'(msec), 2);
    step(6);
    chk("both_run.hold", 32'(msec), 2);
    chk("both_run.stay", 32'(running), 0);

    // both pulses in STOP: clear wins, remain stopped
    pulse(1'b1, 1'b1);
    chk("both_stop.running", 32'(running), 0);
    step(1);
    chk("both_stop.msec", 32'(msec), 0);
    step(5);
    chk("both_stop.stay", 32'(running), 0);
    chk("both_stop.msec_hold", 32'(msec), 0);

    // preload 23:59:59.99 while stopped, then one tick
    force dut.msec = 7'd99;
    force dut.sec = 6'd59;
    force dut.min = 6'd59;
    force dut.hour = 5'd23;
    step(1);
    release dut.msec;
    release dut.sec;
    release dut.min;
    release dut.hour;
    step(1);
    chk_time("preload", 23, 59, 59, 99);
    pulse(1'b1, 1'b0);
    step(3);
    chk_time("pre_roll", 23, 59, 59, 99);
    step(1);
    chk_time("rollover", 0, 0, 0, 0);
    chk("rollover.running", 32'(running), 1);
    step(4);
    chk("after_roll.msec", 32'(msec), 1);

    // asynchronous reset mid-count
    step(2);
    #2 reset = 1'b1;
    #1;
    chk_time("async_reset", 0, 0, 0, 0);
    chk("async_reset.running", 32'(running), 0);
    step(2);
    #2 reset = 1'b0;
    step(8);
    chk("post_reset.running", 32'(running), 0);
    chk("post_reset.msec", 32'(msec), 0);
    pulse(1'b1, 1'b0);
    chk("post_reset.run", 32'(running), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
